counter_arbiter: RTL and testbench

- Shares one up/down occupancy counter between N requesters, each able to ask for INC, DEC or NOP.
- A round-robin arbiter grants at most one request per cycle and applies it to the internal count register.
- Requests that would overflow or underflow the count are never granted.
- Sits in front of shared credit/occupancy resources; downstream logic reads count, full and empty.

---
 rtl/counter_arbiter_pkg.sv | 13 +
 rtl/counter_arbiter_if.sv | 42 ++++
 rtl/counter_arbiter_rr_arbiter.sv | 32 +++
 rtl/counter_arbiter.sv | 101 ++++++++++
 tb/tb_counter_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the arbitrated occupancy counter: op encodings and id-width helper.
package counter_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_INC = 2'b01;
   localparam logic [1:0] OP_DEC = 2'b10;

   // Index width for n requesters; a single requester still gets a 1-bit id.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Request/response bundle between requesters and the counter arbiter.
interface counter_arbiter_if
   import counter_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
);

   localparam int unsigned IW = id_width(N);

   logic [N-1:0]   req_valid;
   logic [2*N-1:0] req_op;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   count;
   logic [1:0]     last_op;
   logic [IW-1:0]  last_id;
   logic           full;
   logic           empty;

   modport master (
      output req_valid,
      output req_op,
      input  req_ready,
      input  count,
      input  last_op,
      input  last_id,
      input  full,
      input  empty
   );

   modport slave (
      input  req_valid,
      input  req_op,
      output req_ready,
      output count,
      output last_op,
      output last_id,
      output full,
      output empty
   );

endinterface

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible bit at or after ptr, wrapping modulo N.
module rr_arbiter
   import counter_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IW = id_width(N)
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any_grant
);

   logic [IW-1:0] slot;

   always_comb begin
      grant     = '0;
      idx       = '0;
      any_grant = 1'b0;
      slot      = '0;
      for (int k = 0; k < int'(N); k++) begin
         slot = IW'((int'(ptr) + k) % int'(N));
         if (!any_grant && elig[slot]) begin
            any_grant   = 1'b1;
            grant[slot] = 1'b1;
            idx         = slot;
         end
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Up/down occupancy counter shared by N requesters; one round-robin-granted op per cycle,
// with INC at MAX and DEC at zero masked out of arbitration so the count never wraps.
module counter_arbiter
   import counter_pkg::*;
#(
   parameter int unsigned   N   = 4,
   parameter int unsigned   W   = 8,
   parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
   input logic              clk,
   input logic              rst_n,
   counter_arbiter_if.slave bus
);

   localparam int unsigned IW = id_width(N);

   logic [W-1:0]  count_q, count_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] last_id_q, last_id_d;
   logic [1:0]    last_op_q, last_op_d;

   logic [N-1:0]  elig;
   logic [N-1:0]  grant;
   logic [IW-1:0] win_idx;
   logic          any_grant;
   logic [1:0]    win_op;

   function automatic logic op_ok(input logic [1:0] op, input logic [W-1:0] cnt);
      logic ok;
      ok = 1'b1;
      if (op == OP_INC) ok = (cnt != MAX);
      else if (op == OP_DEC) ok = (cnt != '0);
      return ok;
   endfunction

   always_comb begin
      elig = '0;
      for (int i = 0; i < int'(N); i++) begin
         elig[i] = bus.req_valid[i] & op_ok(bus.req_op[2*i +: 2], count_q);
      end
   end

   rr_arbiter #(
      .N (N)
   ) u_rr_arbiter (
      .elig      (elig),
      .ptr       (ptr_q),
      .grant     (grant),
      .idx       (win_idx),
      .any_grant (any_grant)
   );

   // Mux the winner's op from the one-hot grant rather than a computed index.
   always_comb begin
      win_op = OP_NOP;
      for (int i = 0; i < int'(N); i++) begin
         if (grant[i]) win_op = bus.req_op[2*i +: 2];
      end
   end

   always_comb begin
      count_d   = count_q;
      ptr_d     = ptr_q;
      last_id_d = last_id_q;
      last_op_d = OP_NOP;
      if (any_grant) begin
         if (win_op == OP_INC) begin
            count_d   = count_q + 1'b1;
            last_op_d = OP_INC;
         end else if (win_op == OP_DEC) begin
            count_d   = count_q - 1'b1;
            last_op_d = OP_DEC;
         end
         last_id_d = win_idx;
         ptr_d     = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         ptr_q     <= '0;
         last_id_q <= '0;
         last_op_q <= OP_NOP;
      end else begin
         count_q   <= count_d;
         ptr_q     <= ptr_d;
         last_id_q <= last_id_d;
         last_op_q <= last_op_d;
      end
   end

   // Ready is held low for the whole reset window, not just until the next edge.
   assign bus.req_ready = grant & {N{rst_n}};
   assign bus.count     = count_q;
   assign bus.last_op   = last_op_q;
   assign bus.last_id   = last_id_q;
   assign bus.full      = (count_q == MAX);
   assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter (N=4, W=3): reference model feeds a scoreboard.
module tb_counter_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned W    = 3;
   localparam int unsigned MAXV = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   counter_arbiter_if #(.N(N), .W(W)) bus ();

   counter_arbiter #(
      .N (N),
      .W (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int unsigned count;
      int unsigned last_op;
      int unsigned last_id;
      int unsigned full;
      int unsigned empty;
   } exp_t;

   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned m_count, m_ptr, m_last_op, m_last_id;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_winner(input logic [N-1:0] v, input logic [2*N-1:0] op);
      for (int k = 0; k < int'(N); k++) begin
         int j;
         logic [1:0] o;
         logic ok;
         j = (int'(m_ptr) + k) % int'(N);
         o = op[2*j +: 2];
         ok = 1'b1;
         if (o == 2'b01) ok = (m_count < MAXV);
         else if (o == 2'b10) ok = (m_count > 0);
         if (v[j] && ok) return j;
      end
      return -1;
   endfunction

   // One clock of stimulus; want >= -1 additionally checks ready against a hand-picked winner.
   task automatic step(input logic [N-1:0] v, input logic [2*N-1:0] op, input int want);
      int w;
      logic [1:0] o;
      logic [31:0] exp_ready;
      exp_t e;
      bus.req_valid = v;
      bus.req_op    = op;
      @(negedge clk);
      w = model_winner(v, op);
      exp_ready = (w < 0) ? 32'd0 : (32'd1 << w);
      check("ready", 32'(bus.req_ready), exp_ready);
      if (want != -2) check("ready_plan", 32'(bus.req_ready), (want < 0) ? 32'd0 : (32'd1 << want));
      if (w >= 0) begin
         o = op[2*w +: 2];
         if (o == 2'b01) m_count++;
         else if (o == 2'b10) m_count--;
         m_last_op = (o == 2'b01 || o == 2'b10) ? 32'(o) : 0;
         m_last_id = w;
         m_ptr     = (w + 1) % N;
      end else begin
         m_last_op = 0;
      end
      sb.push_back('{m_count, m_last_op, m_last_id,
                     (m_count == MAXV) ? 1 : 0, (m_count == 0) ? 1 : 0});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("count", 32'(bus.count), e.count);
      check("last_op", 32'(bus.last_op), e.last_op);
      check("last_id", 32'(bus.last_id), e.last_id);
      check("full", 32'(bus.full), e.full);
      check("empty", 32'(bus.empty), e.empty);
   endtask

   // Asserts reset between clock edges and checks state clears before any edge arrives.
   task automatic apply_reset(input logic [N-1:0] v, input logic [2*N-1:0] op);
      bus.req_valid = v;
      bus.req_op    = op;
      rst_n = 1'b0;
      #1;
      check("rst_count", 32'(bus.count), 0);
      check("rst_last_op", 32'(bus.last_op), 0);
      check("rst_last_id", 32'(bus.last_id), 0);
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_empty", 32'(bus.empty), 1);
      bus.req_valid = '0;
      #1 rst_n = 1'b1;
      m_count = 0; m_ptr = 0; m_last_op = 0; m_last_id = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0]   rv;
      logic [2*N-1:0] ro;
      bus.req_valid = '0;
      bus.req_op    = '0;

      apply_reset(4'hF, 8'h55);

      // Single requester INC
      repeat (3) step(4'b0001, 8'h01, 0);
      check("single_count", 32'(bus.count), 3);
      check("single_last_op", 32'(bus.last_op), 1);
      check("single_last_id", 32'(bus.last_id), 0);

      // Rotation 0,1,2,3,0
      apply_reset(4'hF, 8'h55);
      for (int i = 0; i < 5; i++) step(4'hF, 8'h55, i % 4);
      check("rot_count", 32'(bus.count), 5);

      // Saturation: ptr ends at 0 after req3 fills the counter
      apply_reset(4'hF, 8'h55);
      repeat (7) step(4'b1000, 8'h40, 3);
      check("sat_full", 32'(bus.full), 1);
      step(4'b0011, 8'b0000_1001, 1);
      check("sat_dec_count", 32'(bus.count), 6);
      step(4'b1000, 8'h40, 3);
      repeat (3) step(4'b0001, 8'h01, -1);
      check("sat_hold", 32'(bus.count), 7);

      // Underflow guard
      apply_reset(4'hF, 8'h55);
      repeat (4) step(4'b0100, 8'h20, -1);
      check("uf_empty", 32'(bus.empty), 1);
      step(4'b1100, 8'h60, 3);
      step(4'b0100, 8'h20, 2);
      check("uf_count", 32'(bus.count), 0);

      // NOP consumption at count 5, ptr 1
      apply_reset(4'hF, 8'h55);
      repeat (5) step(4'b0001, 8'h01, 0);
      step(4'b0010, 8'b0000_1100, 1);
      check("nop_count", 32'(bus.count), 5);
      check("nop_last_op", 32'(bus.last_op), 0);
      check("nop_last_id", 32'(bus.last_id), 1);
      step(4'hF, 8'h55, 2);

      // Mid-cycle async reset with count 4, ptr 3, last_id 2
      apply_reset(4'hF, 8'h55);
      repeat (2) step(4'b0001, 8'h01, 0);
      step(4'hF, 8'h55, 1);
      step(4'hF, 8'h55, 2);
      check("pre_rst_count", 32'(bus.count), 4);
      #2;
      apply_reset(4'hF, 8'h55);
      step(4'hF, 8'h55, 0);

      // Random traffic against the model
      for (int i = 0; i < 150; i++) begin
         rv = 4'($urandom_range(0, 15));
         ro = 8'($urandom_range(0, 255));
         step(rv, ro, -2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
